cargador_operandos: RTL and testbench

CARGADOR_OPERANDOS -- requirements
Module: cargador_operandos

---
 rtl/cargador_operandos.sv | 84 ++++++++
 tb/tb_cargador_operandos.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cargador_operandos.sv
// Operand loader: collects A then B from a valid/ready stream, pulses the external
// adder, captures its registered sum and offers it downstream with valid/ready.
// Optional macro CARGADOR_OPERANDOS_CUENTA_EN adds an 8-bit completed-operation counter.
module cargador_operandos #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             enb,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready
`ifdef CARGADOR_OPERANDOS_CUENTA_EN
  ,
  output logic [7:0]       op_count
`endif
);

  typedef enum logic [2:0] {IDLE, GOT_A, CALC, WAIT, RESULT} state_t;

  state_t state, state_nxt;
  logic   accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    enb       = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = GOT_A;
      end
      GOT_A: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        enb       = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:   state_nxt = RESULT;
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The adder registers a+b on the enb cycle, so c is valid during WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      a        <= '0;
      b        <= '0;
      res_data <= '0;
    end else begin
      if (state == IDLE  && accept) a <= in_data;
      if (state == GOT_A && accept) b <= in_data;
      if (state == WAIT)            res_data <= c;
    end
  end

`ifdef CARGADOR_OPERANDOS_CUENTA_EN
  always_ff @(posedge clk) begin
    if (reset)                          op_count <= 8'd0;
    else if (state == RESULT && res_ready) op_count <= op_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_cargador_operandos.sv
// Bench for cargador_operandos: models the external registered adder and checks the
// block against a transaction-level model of the operand/result handshake.
module tb_cargador_operandos;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, in_valid, res_ready;
  logic [W-1:0] in_data;
  logic         in_ready, enb, res_valid;
  logic [W-1:0] a, b, c, res_data;
`ifdef CARGADOR_OPERANDOS_CUENTA_EN
  logic [7:0]   op_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  cargador_operandos #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .enb(enb), .a(a), .b(b), .c(c),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
`ifdef CARGADOR_OPERANDOS_CUENTA_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  // External adder: registered sum, wraps naturally at W bits.
  initial c = '0;
  always @(posedge clk) if (enb) c <= a + b;

  // Transaction model state
  int       words;     // operand words collected for the current operation
  int       since_b;   // edges since the B accept, -1 when no operation in flight
  int       m_a, m_b, m_res, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    words = 0; since_b = -1; m_a = 0; m_b = 0; m_res = 0; m_cnt = 0;
  endtask

  // One clock: check outputs (at negedge), apply inputs, advance model past the edge.
  task automatic step(input bit rv, input bit iv, input int d, input bit rr);
    chk("in_ready",  in_ready,  since_b < 0);
    chk("enb",       enb,       since_b == 0);
    chk("res_valid", res_valid, since_b == 2);
    chk("a",         a,         m_a);
    chk("b",         b,         m_b);
    chk("res_data",  res_data,  m_res);
`ifdef CARGADOR_OPERANDOS_CUENTA_EN
    chk("op_count",  op_count,  m_cnt);
`endif
    reset = rv; in_valid = iv; in_data = W'(d); res_ready = rr;
    @(posedge clk);
    if (rv) model_clear();
    else if (since_b < 0) begin
      if (iv) begin
        if (words == 0) begin m_a = d % (1 << W); words = 1; end
        else begin m_b = d % (1 << W); words = 0; since_b = 0; end
      end
    end else if (since_b < 2) begin
      since_b++;
      if (since_b == 2) m_res = (m_a + m_b) % (1 << W);
    end else if (rr) begin
      since_b = -1;
      m_cnt = (m_cnt + 1) % 256;
    end
    @(negedge clk);
  endtask

  task automatic op(input int x, input int y);
    step(0, 1, x, 1);
    step(0, 1, y, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    op(0, 1);
    op(5, 2);
    op(15, 1);
    chk("wrap_sum", res_data, 0);

    // Result held while res_ready low, with in_valid pulses in that window.
    step(0, 1, 3, 0);
    step(0, 1, 4, 0);
    step(0, 1, 9, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, i[0] == 1'b0, 11, 0);
    chk("held_sum", res_data, 7);
    step(0, 1, 6, 1);
    step(0, 0, 0, 0);

    // Reset after A collected
    step(0, 1, 9, 0);
    step(1, 1, 5, 1);
    op(2, 2);
    chk("post_reset_sum", res_data, 4);

    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 9) < 6));

`ifdef CARGADOR_OPERANDOS_CUENTA_EN
    step(1, 0, 0, 0);
    for (int i = 0; i < 256; i++)
      op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    chk("count_wrap", op_count, 0);
    op(1, 1);
    op(2, 3);
    step(1, 0, 0, 0);
    chk("count_reset", op_count, 0);
`endif

    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
